// File: rtl/dtc_pkg.sv
// Shared defaults and types for the decision-tree leaf enumerator.
// No logic lives here; sizes are the defaults the top-level parameters start from.
package dtc_pkg;

    localparam int DTC_N_INP  = 12;
    localparam int DTC_N_OUT  = 3;
    localparam int DTC_N_LEAF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MATCH = 2'd1,
        EMIT  = 2'd2
    } state_t;

    // One leaf of the tree: the path to it is the set of feature bits in mask,
    // each required to hold the corresponding bit of value.
    typedef struct packed {
        logic                 en;
        logic [DTC_N_OUT-1:0] cls;
        logic [DTC_N_INP-1:0] mask;
        logic [DTC_N_INP-1:0] value;
    } leaf_t;

endpackage

// File: rtl/dtc_prio_enc.sv
// Purpose: lowest-set-bit index of a bitmap plus any/exactly-one flags.
// Latency: purely combinational.
// Backpressure: none; the consumer samples the outputs as it needs them.
module dtc_prio_enc
    import dtc_pkg::*;
#(
    parameter  int N  = DTC_N_LEAF,
    localparam int AW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic [AW-1:0] idx,
    output logic          any,
    output logic          one
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = AW'(i);
            end
        end
    end

    assign any = |vec;
    assign one = any && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/dtc_leaf_enum.sv
// Purpose: inverse DT classifier; streams (mask, value) of every enabled leaf labelled q_class.
// Latency: first beat two cycles after query accept, then one beat per cycle.
// Backpressure: r_ready low holds the current beat stable; no new query is taken until the stream ends.
module dtc_leaf_enum
    import dtc_pkg::*;
#(
    parameter  int N_INP  = DTC_N_INP,
    parameter  int N_OUT  = DTC_N_OUT,
    parameter  int N_LEAF = DTC_N_LEAF,
    localparam int AW     = $clog2(N_LEAF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic             cfg_en,
    input  logic [N_OUT-1:0] cfg_class,
    input  logic [N_INP-1:0] cfg_mask,
    input  logic [N_INP-1:0] cfg_value,
    input  logic             q_valid,
    output logic             q_ready,
    input  logic [N_OUT-1:0] q_class,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [N_INP-1:0] r_mask,
    output logic [N_INP-1:0] r_value,
    output logic [AW-1:0]    r_leaf,
    output logic             r_last,
    output logic             r_none
);

    state_t state, state_nxt;

    logic [N_LEAF-1:0] en;
    logic [N_OUT-1:0]  tcls  [N_LEAF];
    logic [N_INP-1:0]  tmask [N_LEAF];
    logic [N_INP-1:0]  tval  [N_LEAF];

    logic [N_OUT-1:0]  qcls;
    logic [N_LEAF-1:0] hit;
    logic [N_LEAF-1:0] pend;
    logic [AW-1:0]     idx;
    logic              any;
    logic              one;
    logic              tbl_wr;

    // The table is only writable between queries so a stream always sees one snapshot.
    assign tbl_wr = cfg_we && (state == IDLE);

    always_ff @(posedge clk) begin
        if (tbl_wr) begin
            tcls[cfg_addr]  <= cfg_class;
            tmask[cfg_addr] <= cfg_mask;
            tval[cfg_addr]  <= cfg_value;
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < N_LEAF; i++) begin
            hit[i] = en[i] && (tcls[i] == qcls);
        end
    end

    dtc_prio_enc #(
        .N   (N_LEAF)
    ) u_prio (
        .vec (pend),
        .idx (idx),
        .any (any),
        .one (one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An empty pending map in EMIT can only mean the query matched nothing,
    // because the last real beat returns straight to IDLE.
    always_comb begin
        state_nxt = state;
        q_ready   = 1'b0;
        r_valid   = 1'b0;
        r_last    = 1'b0;
        r_none    = 1'b0;
        r_mask    = '0;
        r_value   = '0;
        r_leaf    = '0;
        case (state)
            IDLE: begin
                q_ready = 1'b1;
                if (q_valid) begin
                    state_nxt = MATCH;
                end
            end
            MATCH: begin
                state_nxt = EMIT;
            end
            EMIT: begin
                r_valid = 1'b1;
                if (!any) begin
                    r_none = 1'b1;
                    r_last = 1'b1;
                end else begin
                    r_mask  = tmask[idx];
                    r_value = tval[idx] & tmask[idx];
                    r_leaf  = idx;
                    r_last  = one;
                end
                if (r_ready && (!any || one)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en   <= '0;
            pend <= '0;
        end else begin
            if (tbl_wr) begin
                en[cfg_addr] <= cfg_en;
            end
            case (state)
                IDLE: begin
                    if (q_valid) begin
                        qcls <= q_class;
                    end
                end
                MATCH: begin
                    pend <= hit;
                end
                EMIT: begin
                    if (r_ready && any) begin
                        pend[idx] <= 1'b0;
                    end
                end
                default: begin
                    pend <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtc_leaf_enum.sv
// Scoreboard bench for dtc_leaf_enum: stimulus queues expected beats, a negedge monitor pops and compares.
module tb_dtc_leaf_enum;
    import dtc_pkg::*;

    localparam int NI = 12;
    localparam int NO = 3;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic          cfg_en = 1'b0;
    logic [NO-1:0] cfg_class = '0;
    logic [NI-1:0] cfg_mask = '0;
    logic [NI-1:0] cfg_value = '0;
    logic          q_valid = 1'b0;
    logic          q_ready;
    logic [NO-1:0] q_class = '0;
    logic          r_valid;
    logic          r_ready = 1'b0;
    logic [NI-1:0] r_mask;
    logic [NI-1:0] r_value;
    logic [AW-1:0] r_leaf;
    logic          r_last;
    logic          r_none;

    dtc_leaf_enum dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_en    (cfg_en),
        .cfg_class (cfg_class),
        .cfg_mask  (cfg_mask),
        .cfg_value (cfg_value),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .q_class   (q_class),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_mask    (r_mask),
        .r_value   (r_value),
        .r_leaf    (r_leaf),
        .r_last    (r_last),
        .r_none    (r_none)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NI-1:0] mask;
        logic [NI-1:0] value;
        logic [AW-1:0] leaf;
        logic          last;
        logic          none;
    } beat_t;

    beat_t sb[$];
    int    checks   = 0;
    int    failures = 0;
    int    rr_mode  = 0;   // 0: always ready, 1: toggling, 2: driven by stimulus

    function automatic beat_t mk(input logic [NI-1:0] m, input logic [NI-1:0] v,
                                 input logic [AW-1:0] l, input logic last, input logic none);
        beat_t b;
        b.mask  = m;
        b.value = v;
        b.leaf  = l;
        b.last  = last;
        b.none  = none;
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input leaf_t l);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_en    = l.en;
        cfg_class = l.cls;
        cfg_mask  = l.mask;
        cfg_value = l.value;
        tick();
        cfg_we    = 1'b0;
    endtask

    // Issues a query (optionally with a same-cycle table write) and checks first-beat latency.
    task automatic query(input logic [NO-1:0] c, input bit do_wr, input logic [AW-1:0] a, input leaf_t l);
        int lat;
        q_valid = 1'b1;
        q_class = c;
        if (do_wr) begin
            cfg_we    = 1'b1;
            cfg_addr  = a;
            cfg_en    = l.en;
            cfg_class = l.cls;
            cfg_mask  = l.mask;
            cfg_value = l.value;
        end
        @(negedge clk);
        check("q_ready_at_accept", q_ready, 1);
        tick();
        q_valid = 1'b0;
        cfg_we  = 1'b0;
        lat = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (r_valid) break;
            @(posedge clk);
            lat++;
        end
        check("first_beat_latency", lat, 2);
    endtask

    // Waits for the stream to drain; nbeats counts cycles with r_valid high.
    task automatic wait_done(output int nbeats);
        bit ok;
        ok     = 1'b0;
        nbeats = int'(r_valid);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (r_valid) nbeats++;
            if (q_ready && !r_valid && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: q_ready=%0b pending=%0d expected idle with 0 pending", q_ready, sb.size());
        end else begin
            check("idle_outputs_zero", {r_mask, r_value, r_leaf, r_last, r_none}, 0);
        end
        tick();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_mode == 0) r_ready = 1'b1;
            else if (rr_mode == 1) r_ready = ~r_ready;
        end
    end

    // Monitor: compares every transferred beat, and checks payload holds across stalls.
    initial begin
        beat_t got;
        beat_t exp;
        beat_t held;
        logic  stalled;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!rst && r_valid) begin
                got = {r_mask, r_value, r_leaf, r_last, r_none};
                if (stalled) check("stall_payload_stable", got, held);
                if (r_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat: got 0x%0h expected no beat", got);
                    end else begin
                        exp = sb.pop_front();
                        check("beat", got, exp);
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = got;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    n;
        leaf_t z;
        z = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_r_valid", r_valid, 0);
        check("rst_q_ready", q_ready, 1);
        check("rst_payload", {r_mask, r_value, r_leaf, r_last, r_none}, 0);
        tick();
        rst = 1'b0;
        tick();

        // Two leaves, query picks leaf 1 only
        wr(4'd0, '{1'b1, 3'b001, 12'h258, 12'h000});
        wr(4'd1, '{1'b1, 3'b010, 12'h258, 12'h010});
        sb.push_back(mk(12'h258, 12'h010, 4'd1, 1'b1, 1'b0));
        query(3'b010, 1'b0, 4'd0, z);
        wait_done(n);
        check("beats_single", n, 1);

        // Three matches back to back; disabled leaf 7 with the same label must not appear
        wr(4'd2,  '{1'b1, 3'b000, 12'h00F, 12'h005});
        wr(4'd5,  '{1'b1, 3'b000, 12'h0F0, 12'h0A0});
        wr(4'd9,  '{1'b1, 3'b000, 12'hF00, 12'hFFF});
        wr(4'd7,  '{1'b0, 3'b000, 12'hFFF, 12'hFFF});
        wr(4'd15, '{1'b1, 3'b110, 12'h0AA, 12'h0F0});
        sb.push_back(mk(12'h00F, 12'h005, 4'd2, 1'b0, 1'b0));
        sb.push_back(mk(12'h0F0, 12'h0A0, 4'd5, 1'b0, 1'b0));
        sb.push_back(mk(12'hF00, 12'hF00, 4'd9, 1'b1, 1'b0));
        query(3'b000, 1'b0, 4'd0, z);
        wait_done(n);
        check("beats_consecutive", n, 3);

        // Top leaf index, value bits outside mask dropped
        sb.push_back(mk(12'h0AA, 12'h0A0, 4'd15, 1'b1, 1'b0));
        query(3'b110, 1'b0, 4'd0, z);
        wait_done(n);
        check("beats_top_leaf", n, 1);

        // No match
        sb.push_back(mk(12'h000, 12'h000, 4'd0, 1'b1, 1'b1));
        query(3'b111, 1'b0, 4'd0, z);
        wait_done(n);
        check("beats_none", n, 1);
        check("q_ready_after_none", q_ready, 1);

        // Toggling r_ready with a table write attempted mid-stream
        rr_mode = 1;
        sb.push_back(mk(12'h00F, 12'h005, 4'd2, 1'b0, 1'b0));
        sb.push_back(mk(12'h0F0, 12'h0A0, 4'd5, 1'b0, 1'b0));
        sb.push_back(mk(12'hF00, 12'hF00, 4'd9, 1'b1, 1'b0));
        query(3'b000, 1'b0, 4'd0, z);
        wr(4'd5, '{1'b0, 3'b111, 12'h000, 12'h000});
        wait_done(n);
        rr_mode = 0;
        tick();

        // Write and query in the same cycle
        sb.push_back(mk(12'h123, 12'h023, 4'd3, 1'b1, 1'b0));
        query(3'b100, 1'b1, 4'd3, '{1'b1, 3'b100, 12'h123, 12'h0FF});
        wait_done(n);
        check("beats_same_cycle_write", n, 1);

        // Reset on the second beat of the 000 stream
        rr_mode = 2;
        r_ready = 1'b1;
        sb.push_back(mk(12'h00F, 12'h005, 4'd2, 1'b0, 1'b0));
        query(3'b000, 1'b0, 4'd0, z);
        tick();
        r_ready = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        check("second_beat_leaf", r_leaf, 5);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_abort_r_valid", r_valid, 0);
        check("rst_abort_q_ready", q_ready, 1);
        check("rst_abort_no_pending", sb.size(), 0);
        tick();
        rr_mode = 0;
        tick();

        sb.push_back(mk(12'h000, 12'h000, 4'd0, 1'b1, 1'b1));
        query(3'b000, 1'b0, 4'd0, z);
        wait_done(n);
        check("beats_after_rst_000", n, 1);

        sb.push_back(mk(12'h000, 12'h000, 4'd0, 1'b1, 1'b1));
        query(3'b100, 1'b0, 4'd0, z);
        wait_done(n);
        check("beats_after_rst_100", n, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dtc_leaf_enum.md
DTC_LEAF_ENUM -- requirements
Module: dtc_leaf_enum

Interface
REQ-001 The block SHALL have parameter N_INP, default 12, giving the feature-vector width.
REQ-002 The block SHALL have parameter N_OUT, default 3, giving the class-label width.
REQ-003 The block SHALL have parameter N_LEAF, default 16, giving the leaf-table depth (power of two).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port cfg_we, input, 1 bit: leaf-table write strobe.
REQ-007 The block SHALL have port cfg_addr, input, log2(N_LEAF) bits: leaf index to write.
REQ-008 The block SHALL have port cfg_en, input, 1 bit: enable bit of the leaf being written.
REQ-009 The block SHALL have port cfg_class, input, N_OUT bits: class label of the leaf.
REQ-010 The block SHALL have port cfg_mask, input, N_INP bits: the feature bits tested on the path to the leaf.
REQ-011 The block SHALL have port cfg_value, input, N_INP bits: the required values of the masked bits.
REQ-012 The block SHALL have port q_valid, input, 1 bit: a query is presented.
REQ-013 The block SHALL have port q_ready, output, 1 bit: a query can be accepted.
REQ-014 The block SHALL have port q_class, input, N_OUT bits: the target class of the query.
REQ-015 The block SHALL have port r_valid, output, 1 bit: a response beat is presented.
REQ-016 The block SHALL have port r_ready, input, 1 bit: the consumer accepts the beat.
REQ-017 The block SHALL have port r_mask, output, N_INP bits: input-constraint mask of the beat.
REQ-018 The block SHALL have port r_value, output, N_INP bits: input-constraint values of the beat.
REQ-019 The block SHALL have port r_leaf, output, log2(N_LEAF) bits: index of the matching leaf.
REQ-020 The block SHALL have port r_last, output, 1 bit: final beat of the response.
REQ-021 The block SHALL have port r_none, output, 1 bit: the query matched no leaf.

Function
REQ-022 The block SHALL implement the inverse of a DT classifier: for a target class, it SHALL stream every enabled leaf whose label equals q_class, as (mask, value) input constraints.
REQ-023 The FSM SHALL have the states IDLE, MATCH and EMIT; q_ready SHALL equal (state==IDLE).
REQ-024 IDLE->MATCH SHALL occur when q_valid&&q_ready; q_class SHALL be captured on that edge.
REQ-025 In MATCH, the pending bitmap SHALL be loaded with bit i = en[i] && class[i]==captured class, and the FSM SHALL go to EMIT; r_valid SHALL therefore first assert two cycles after query accept.
REQ-026 In EMIT, the beat SHALL present the lowest set bitmap index; r_mask = mask[idx] & value-independent, r_value = value[idx] & mask[idx], r_leaf = idx.
REQ-027 r_last SHALL be 1 when exactly one pending bit remains.
REQ-028 A beat SHALL transfer on r_valid&&r_ready; on transfer, the idx bit SHALL be cleared, and the FSM SHALL return to IDLE after the last beat.
REQ-029 Payload SHALL remain stable while r_valid&&!r_ready.
REQ-030 With sustained r_ready, the block SHALL sustain one beat per cycle.
REQ-031 Empty bitmap in MATCH: EMIT SHALL present one beat with r_none=1, r_last=1, r_mask=r_value=0, r_leaf=0.
REQ-032 cfg_we in IDLE SHALL write the entry; cfg_we in MATCH/EMIT SHALL be ignored (table frozen per query).
REQ-033 cfg_we together with an accepted query in the same IDLE cycle: the write SHALL take effect and MATCH SHALL see the post-write table.
REQ-034 When r_valid is 0, r_* SHALL be driven to 0.

Reset
REQ-035 rst SHALL force IDLE, clear all en bits and the bitmap, and drive r_valid=r_last=r_none=0, r_mask=r_value=r_leaf=0, q_ready=1 on the next cycle.
REQ-036 rst SHALL dominate all other inputs; rst mid-EMIT SHALL abort the stream without a further beat.
REQ-037 Class/mask/value table storage SHALL need no reset.

Structure
REQ-038 Package dtc_pkg SHALL hold N_INP/N_OUT/N_LEAF defaults, the state enum, and the leaf_t struct {en, class, mask, value}.
REQ-039 The lowest-set-bit selection and one-remaining detection SHALL live in sub-module dtc_prio_enc (N_LEAF-bit in; idx, any, one out).

Verification
REQ-040 Load leaf0 {1, 001, 0x258, 0x000} and leaf1 {1, 010, 0x258, 0x010}, then query 010 -> one beat with r_leaf=1, r_mask=0x258, r_value=0x010, r_last=1, first r_valid 2 cycles after accept.
REQ-041 Label leaves 2, 5 and 9 with 000 and enable them, then query 000 with r_ready=1 -> beats with leaf 2, 5, 9 on consecutive cycles; r_last only on leaf 9.
REQ-042 Query 111 with no match -> single beat with r_none=1, r_last=1, followed by q_ready=1.
REQ-043 Same as REQ-041, but r_ready toggles 0/1 -> payload stable while stalled; no beat dropped or duplicated; cfg_we mid-stream is ignored.
REQ-044 Assert rst during the second beat of REQ-041 -> r_valid=0 next cycle, en all 0, and a subsequent query 000 returns r_none=1.
REQ-045 Write leaf3 class 100 in the same cycle as a query 100 is accepted -> leaf 3 is returned.
